dm_request_issuer: RTL
======================

DM_REQUEST_ISSUER -- requirements
Module: dm_request_issuer

Interface
REQ-001 Parameter DATA_ADDR_WIDTH, default 32: memory address width.
REQ-002 Parameter TRACE_ENTRIES, default 65536: trace repository depth; index width is IW = clog2(TRACE_ENTRIES).
REQ-003 Parameter TRACKER_DEPTH, default 4: number of tracker slots, a power of two.
REQ-004 Parameter LINE_OFFSET, default 4: low address bits ignored for line comparison.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  trace entry offered by the repository.
REQ-008 in_ready  out  1  entry accepted when in_valid and in_ready are both high.
REQ-009 in_trace_index  in  IW  repository index of the offered entry.
REQ-010 in_mem_addr  in  DATA_ADDR_WIDTH  data address of the offered entry.
REQ-011 mem_req  out  1  cache request strobe.
REQ-012 mem_addr  out  DATA_ADDR_WIDTH  request address.
REQ-013 mem_gnt  in  1  cache accepted the request.
REQ-014 mem_rvalid  in  1  cache finished the granted request.
REQ-015 retire_valid  out  1  one-cycle pulse: head request retired.
REQ-016 retire_trace_index  out  IW  index of the retired entry.
REQ-017 retire_mem_addr  out  DATA_ADDR_WIDTH  address of the retired entry.
REQ-018 merge_count  out  16  saturating count of merged entries.

Function
REQ-019 Tracker SHALL be a circular FIFO of TRACKER_DEPTH cache_tracker_t slots with head/tail pointers that wrap modulo TRACKER_DEPTH.
REQ-020 in_ready SHALL equal (occupied slot count < TRACKER_DEPTH), from registered state only; at full it is 0.
REQ-021 An accepted, non-merged entry SHALL be written at tail with occupied=1, processing=0, and tail SHALL advance.
REQ-022 The issue FSM SHALL use mem_action states MAKE_REQUEST, WAIT_FOR_PROCESSING and REQUEST_RETIRED.
REQ-023 In MAKE_REQUEST, mem_req SHALL equal the head slot's occupied bit, and mem_addr SHALL equal the head slot's mem_addr.
REQ-024 MAKE_REQUEST with mem_req and mem_gnt high SHALL set head processing=1 and go to WAIT_FOR_PROCESSING; mem_req SHALL hold, with a stable address, until then.
REQ-025 WAIT_FOR_PROCESSING SHALL drive mem_req=0 and go to REQUEST_RETIRED on mem_rvalid; mem_rvalid SHALL be ignored in every other state.
REQ-026 REQUEST_RETIRED SHALL pulse retire_valid with the head slot's index and address, clear the head slot, advance head and return to MAKE_REQUEST.
REQ-027 Latency: an entry accepted into an empty tracker in MAKE_REQUEST SHALL raise mem_req on the next cycle; with gnt on the first request cycle and rvalid on the next cycle, retire_valid SHALL occur 2 cycles after rvalid is sampled.
REQ-028 An accept and a retire in the same cycle SHALL both take effect, and the count SHALL be unchanged.
REQ-029 When retire_valid=0, retire_trace_index and retire_mem_addr SHALL be 0.

Reset
REQ-030 With rst high, the block SHALL clear all slots, set head=tail=0, set the FSM to MAKE_REQUEST and clear merge_count.
REQ-031 Reset values: in_ready=0 during rst and 1 in the first cycle after it; mem_req=0, retire_valid=0, merge_count=0.
REQ-032 Reset mid-operation SHALL drop all outstanding requests without a retire pulse.

Configuration
REQ-033 With DM_ISSUER_MERGE_EN defined, an accepted entry whose in_mem_addr[DATA_ADDR_WIDTH-1:LINE_OFFSET] matches any occupied slot SHALL NOT be allocated, and merge_count SHALL increment, saturating at 16'hFFFF.
REQ-034 The merge match SHALL include the head slot, also while it is processing or retiring.
REQ-035 Without DM_ISSUER_MERGE_EN, every accepted entry SHALL be allocated and merge_count SHALL be tied to 0.

Verification
REQ-036 Single entry: idx 5, addr 0x100 into empty tracker; gnt on first req cycle; rvalid next cycle -> one retire pulse, idx 5, addr 0x100.
REQ-037 Fill: 4 distinct lines with gnt held low -> in_ready=0 after the 4th accept; one retire -> in_ready=1 on the next cycle.
REQ-038 Simultaneous: an accept in the REQUEST_RETIRED cycle -> slot count unchanged; tail wraps 3->0 correctly.
REQ-039 Merge (macro on): addr 0x200 then 0x208 -> one mem_req, merge_count=1; macro off -> two requests, merge_count=0.
REQ-040 Protocol: mem_rvalid asserted in MAKE_REQUEST -> ignored; mem_req held with a stable address during 3 cycles of gnt low.
REQ-041 Reset mid-operation in WAIT_FOR_PROCESSING with 3 slots occupied -> no retire pulse; all outputs at reset values; a following rvalid is ignored.

Source files
------------

// File: rtl/dm_request_issuer_if.sv
// Issuer bus bundle: trace-entry input, cache request/response and retire outputs.
// The master modport is the issuer's own view; slave is the surrounding system.
interface dm_request_issuer_if #(
   parameter int unsigned DATA_ADDR_WIDTH = 32,
   parameter int unsigned IW              = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [IW-1:0]              in_trace_index;
   logic [DATA_ADDR_WIDTH-1:0] in_mem_addr;
   logic                       mem_req;
   logic [DATA_ADDR_WIDTH-1:0] mem_addr;
   logic                       mem_gnt;
   logic                       mem_rvalid;
   logic                       retire_valid;
   logic [IW-1:0]              retire_trace_index;
   logic [DATA_ADDR_WIDTH-1:0] retire_mem_addr;
   logic [15:0]                merge_count;

   modport master (
      input  in_valid, in_trace_index, in_mem_addr, mem_gnt, mem_rvalid,
      output in_ready, mem_req, mem_addr, retire_valid, retire_trace_index,
             retire_mem_addr, merge_count
   );

   modport slave (
      output in_valid, in_trace_index, in_mem_addr, mem_gnt, mem_rvalid,
      input  in_ready, mem_req, mem_addr, retire_valid, retire_trace_index,
             retire_mem_addr, merge_count
   );
endinterface

// File: rtl/dm_request_issuer.sv
// Tracks trace entries in a circular FIFO and issues one cache request at a time.
// Optional same-line merging is enabled by defining DM_ISSUER_MERGE_EN.
module dm_request_issuer #(
   parameter int unsigned DATA_ADDR_WIDTH = 32,
   parameter int unsigned TRACE_ENTRIES   = 65536,
   parameter int unsigned TRACKER_DEPTH   = 4,
   parameter int unsigned LINE_OFFSET     = 4
) (
   input logic                 clk,
   input logic                 rst,
   dm_request_issuer_if.master bus
);
   localparam int unsigned IW = $clog2(TRACE_ENTRIES);
   localparam int unsigned PW = $clog2(TRACKER_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic                       occupied;
      logic                       processing;
      logic [IW-1:0]              trace_index;
      logic [DATA_ADDR_WIDTH-1:0] mem_addr;
   } cache_tracker_t;

   typedef enum logic [1:0] {
      MAKE_REQUEST,
      WAIT_FOR_PROCESSING,
      REQUEST_RETIRED
   } mem_action_t;

   cache_tracker_t             r_slots [TRACKER_DEPTH];
   logic [PW-1:0]              r_head;
   logic [PW-1:0]              r_tail;
   logic [CW-1:0]              r_count;
   mem_action_t                r_state;
   mem_action_t                w_state_next;
   logic                       r_retire_valid;
   logic [IW-1:0]              r_retire_idx;
   logic [DATA_ADDR_WIDTH-1:0] r_retire_addr;

   logic w_in_ready;
   logic w_accept;
   logic w_alloc;
   logic w_mem_req;
   logic w_grant;
   logic w_retire;

   // rst gates readiness directly so nothing is offered as accepted while held in reset
   assign w_in_ready = !rst && (r_count < CW'(TRACKER_DEPTH));
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      w_state_next = r_state;
      w_mem_req    = 1'b0;
      w_grant      = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         MAKE_REQUEST: begin
            w_mem_req = r_slots[r_head].occupied;
            if (w_mem_req && bus.mem_gnt) begin
               w_grant      = 1'b1;
               w_state_next = WAIT_FOR_PROCESSING;
            end
         end
         WAIT_FOR_PROCESSING: begin
            if (bus.mem_rvalid) w_state_next = REQUEST_RETIRED;
         end
         REQUEST_RETIRED: begin
            w_retire     = 1'b1;
            w_state_next = MAKE_REQUEST;
         end
         default: w_state_next = MAKE_REQUEST;
      endcase
   end

`ifdef DM_ISSUER_MERGE_EN
   logic        w_line_hit;
   logic [15:0] r_merge_count;

   // Head slot stays occupied through WAIT and RETIRED, so it participates in matching
   always_comb begin
      w_line_hit = 1'b0;
      for (int unsigned i = 0; i < TRACKER_DEPTH; i++) begin
         if (r_slots[i].occupied &&
             (r_slots[i].mem_addr[DATA_ADDR_WIDTH-1:LINE_OFFSET] ==
              bus.in_mem_addr[DATA_ADDR_WIDTH-1:LINE_OFFSET]))
            w_line_hit = 1'b1;
      end
   end

   assign w_alloc = w_accept && !w_line_hit;

   always_ff @(posedge clk) begin
      if (rst)
         r_merge_count <= '0;
      else if (w_accept && w_line_hit && (r_merge_count != 16'hFFFF))
         r_merge_count <= r_merge_count + 16'd1;
   end

   assign bus.merge_count = r_merge_count;
`else
   assign w_alloc         = w_accept;
   assign bus.merge_count = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < TRACKER_DEPTH; i++) r_slots[i] <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_state        <= MAKE_REQUEST;
         r_retire_valid <= 1'b0;
         r_retire_idx   <= '0;
         r_retire_addr  <= '0;
      end else begin
         r_state        <= w_state_next;
         r_retire_valid <= w_retire;
         r_retire_idx   <= w_retire ? r_slots[r_head].trace_index : '0;
         r_retire_addr  <= w_retire ? r_slots[r_head].mem_addr : '0;
         if (w_grant) r_slots[r_head].processing <= 1'b1;
         if (w_retire) begin
            r_slots[r_head] <= '0;
            r_head          <= r_head + 1'b1;
         end
         // Full tracker refuses input, so tail never lands on the retiring head slot
         if (w_alloc) begin
            r_slots[r_tail] <= '{occupied: 1'b1, processing: 1'b0,
                                 trace_index: bus.in_trace_index,
                                 mem_addr: bus.in_mem_addr};
            r_tail          <= r_tail + 1'b1;
         end
         case ({w_alloc, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready           = w_in_ready;
   assign bus.mem_req            = w_mem_req;
   assign bus.mem_addr           = r_slots[r_head].mem_addr;
   assign bus.retire_valid       = r_retire_valid;
   assign bus.retire_trace_index = r_retire_idx;
   assign bus.retire_mem_addr    = r_retire_addr;
endmodule
